data_sram_bridge: RTL and testbench

Converts the CPU's single-cycle data SRAM port into a request/response bus transaction with stall generation, for data memory that takes more than one cycle. Sits between the memory-access stage and the data bus. Upstream it consumes the aligned byte-write enables and the shifted store data that the memory stage produces. Downstream it returns the raw 32-bit read word, which the memory stage aligns and sign/zero-extends.

---
 rtl/data_sram_bridge.sv | 183 ++++++++++++++++++
 tb/tb_data_sram_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns the CPU's single-cycle data SRAM port into a
// request/response bus transaction and stalls the pipeline until it completes.
// Optional feature macro: DSRAM_RDATA_BYPASS_EN (forward bus_rdata to the
// memory stage in the response cycle instead of waiting for DONE).
module data_sram_bridge #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_req,
    input  logic [3:0]            cpu_wen,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic                  cpu_cancel,
    input  logic                  pipe_hold,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_wstrb,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [31:0]           bus_rdata
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  drain;
    logic                  drain_c;
    logic                  accept_c;
    logic                  complete_c;
    logic                  in_flight_c;
    logic [DATA_W-1:0]     resp_c;

    logic                  wr_q;
    logic [1:0]            size_q;
    logic [3:0]            wstrb_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rbuf;

    // Transfer size implied by the aligned byte enables (reads are whole words)
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    // Shared decode of handshake and cancel conditions
    always_comb begin
        accept_c    = (state == S_IDLE) && cpu_req && !cpu_cancel;
        in_flight_c = (state == S_ADDR) || (state == S_DATA);
        drain_c     = drain || (in_flight_c && cpu_cancel);
        complete_c  = (state == S_DATA) && bus_data_ok;
        resp_c      = wr_q ? '0 : bus_rdata;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an accepted request always runs to its response
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    if (drain_c) begin
                        next_state = S_IDLE;
                    end else begin
`ifdef DSRAM_RDATA_BYPASS_EN
                        next_state = pipe_hold ? S_DONE : S_IDLE;
`else
                        next_state = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                if (cpu_cancel || !pipe_hold) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: stall and read data toward the memory stage
    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = rbuf;
        case (state)
            S_IDLE: cpu_stall = cpu_req && !cpu_cancel;
            S_ADDR: cpu_stall = 1'b1;
            S_DATA: begin
                cpu_stall = 1'b1;
`ifdef DSRAM_RDATA_BYPASS_EN
                if (complete_c && !drain_c) begin
                    cpu_stall = 1'b0;
                    cpu_rdata = resp_c;
                end
`endif
            end
            S_DONE: cpu_stall = 1'b0;
            default: cpu_stall = 1'b0;
        endcase
    end

    // Request is valid only while waiting for the address handshake
    assign bus_req   = (state == S_ADDR);
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;

    // Latch the request fields, already encoded for the bus, on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            wr_q    <= |cpu_wen;
            size_q  <= size_of(cpu_wen);
            wstrb_q <= cpu_wen;
            addr_q  <= (|cpu_wen) ? cpu_addr : {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= cpu_wdata;
        end
    end

    // Read buffer keeps its value when a cancelled transaction drains
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rbuf <= '0;
        end else if (complete_c && !drain_c) begin
            rbuf <= resp_c;
        end
    end

    // Drain flag lives only while a cancelled transaction is still on the bus
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drain <= 1'b0;
        end else begin
            drain <= ((next_state == S_ADDR) || (next_state == S_DATA)) ? drain_c : 1'b0;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed scenarios plus randomized
// accesses against a transaction-level expectation model.
module tb_data_sram_bridge;

    localparam int unsigned AW = 32;
`ifdef DSRAM_RDATA_BYPASS_EN
    localparam int MIN_STALL = 2;
`else
    localparam int MIN_STALL = 3;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          cpu_req;
    logic [3:0]    cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_cancel;
    logic          pipe_hold;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_wstrb;
    logic [31:0]   bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [31:0]   bus_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    data_sram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_cancel(cpu_cancel), .pipe_hold(pipe_hold),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic quiet_inputs();
        cpu_req     = 1'b0;
        cpu_wen     = 4'd0;
        cpu_cancel  = 1'b0;
        pipe_hold   = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
    endtask

    // One complete access; bus latencies and hold length given in cycles
    task automatic run_access(input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] resp,
                              input int alat, input int dlat, input int hold);
        bit          is_wr = (wen != 4'd0);
        int          ones = $countones(wen);
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        int          stall_cnt = 0;
        int          req_seen = 0;
        int          dwait = -1;
        int          k = 0;
        int          cyc = 0;
        bit          got_data = 0;
        bit          done = 0;

        exp_size = !is_wr ? 2'd2 : (ones == 1) ? 2'd0 : (ones == 2) ? 2'd1 : 2'd2;
        exp_addr = is_wr ? addr : (addr & 32'hFFFF_FFFC);
        exp_rd   = is_wr ? 32'd0 : resp;

        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_wen   = wen;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        pipe_hold = (hold > 0);
        while (!done && cyc < 200) begin
            bus_addr_ok = bus_req && (req_seen == alat);
            bus_data_ok = !got_data && (dwait == dlat);
            bus_rdata   = (bus_data_ok && !is_wr) ? resp : $urandom;
            #1;
            if (bus_req) begin
                check_eq("bus_ctrl", 64'({bus_wr, bus_size, bus_wstrb, bus_addr}),
                         64'({is_wr, exp_size, wen, exp_addr}));
                check_eq("bus_wdata", 64'(bus_wdata), 64'(wdata));
            end
            if (k == 0 && cpu_stall) begin
                stall_cnt++;
            end else begin
                if (k == 0) check_eq("stall_cycles", 64'(stall_cnt), 64'(MIN_STALL + alat + dlat));
                else        check_eq("stall_after_done", 64'(cpu_stall), 64'd0);
                check_eq("no_reissue", 64'(bus_req), 64'd0);
                check_eq("cpu_rdata", 64'(cpu_rdata), 64'(exp_rd));
                pipe_hold = (k < hold);
                if (k >= hold) done = 1;
                k++;
            end
            if (dwait >= 0 && !got_data) dwait++;
            if (bus_req && bus_addr_ok) dwait = 0;
            if (bus_req) req_seen++;
            if (bus_data_ok) got_data = 1;
            cyc++;
            if (!done) @(negedge clk);
        end
        check_eq("access_done", 64'(done), 64'd1);
        model_rdata = exp_rd;
    endtask

    // Cancel while the transaction is in ADDR or DATA; it must drain silently
    task automatic run_cancel(input bit in_addr);
        logic [31:0] prev = model_rdata;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_3004; pipe_hold = 1'b0;
        #1 check_eq("cxl_t0_stall", 64'(cpu_stall), 64'd1);
        @(negedge clk);
        if (in_addr) begin cpu_cancel = 1'b1; bus_addr_ok = 1'b0; end
        else         bus_addr_ok = 1'b1;
        #1 check_eq("cxl_t1_req", 64'(bus_req), 64'd1);
        @(negedge clk);
        if (in_addr) begin cpu_cancel = 1'b0; cpu_req = 1'b0; bus_addr_ok = 1'b1; end
        else         begin cpu_cancel = 1'b1; bus_addr_ok = 1'b0; end
        #1 check_eq("cxl_t2_req", 64'(bus_req), 64'(in_addr));
        check_eq("cxl_t2_stall", 64'(cpu_stall), 64'd1);
        @(negedge clk);
        cpu_cancel = 1'b0; cpu_req = 1'b0; bus_addr_ok = 1'b0;
        #1 check_eq("cxl_t3_stall", 64'(cpu_stall), 64'd1);
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        #1 check_eq("cxl_drain_stall", 64'(cpu_stall), 64'd1);
        check_eq("cxl_drain_rdata", 64'(cpu_rdata), 64'(prev));
        @(negedge clk);
        bus_data_ok = 1'b0; bus_rdata = 32'd0;
        #1 check_eq("cxl_after_stall", 64'(cpu_stall), 64'd0);
        check_eq("cxl_after_req", 64'(bus_req), 64'd0);
        check_eq("cxl_after_rdata", 64'(cpu_rdata), 64'(prev));
    endtask

    initial begin
        logic [3:0] legal_wen [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                      4'b1000, 4'b0011, 4'b1100, 4'b1111};
        quiet_inputs();
        cpu_addr = '0;
        cpu_wdata = '0;
        resetn = 1'b0;
        model_rdata = 32'd0;
        #1;
        check_eq("reset_outputs", 64'({bus_req, bus_wr, bus_size, bus_wstrb, cpu_stall}), 64'd0);
        check_eq("reset_addr", 64'(bus_addr), 64'd0);
        check_eq("reset_wdata", 64'(bus_wdata), 64'd0);
        check_eq("reset_rdata", 64'(cpu_rdata), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Cancel together with the request in IDLE: nothing is issued
        @(negedge clk);
        cpu_req = 1'b1; cpu_cancel = 1'b1;
        #1 check_eq("idle_cancel_stall", 64'(cpu_stall), 64'd0);
        @(negedge clk);
        cpu_req = 1'b0; cpu_cancel = 1'b0;
        #1 check_eq("idle_cancel_req", 64'(bus_req), 64'd0);

        run_cancel(1'b0);
        run_access(4'b0000, 32'h0000_1003, 32'h5555_5555, 32'hDEAD_BEEF, 0, 0, 0);
        run_access(4'b1100, 32'h0000_2002, 32'hABCD_0000, 32'h0, 4, 0, 0);
        run_access(4'b0000, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 1, 2, 3);
        run_cancel(1'b1);

        // Reset while a request is waiting in ADDR
        @(negedge clk);
        quiet_inputs();
        cpu_req = 1'b1; cpu_addr = 32'h0000_5000;
        @(negedge clk);
        #1 check_eq("rst_pre_req", 64'(bus_req), 64'd1);
        resetn = 1'b0;
        #1 check_eq("rst_req", 64'(bus_req), 64'd0);
        check_eq("rst_rdata", 64'(cpu_rdata), 64'd0);
        check_eq("rst_addr", 64'(bus_addr), 64'd0);
        model_rdata = 32'd0;
        @(negedge clk);
        cpu_req = 1'b0;
        resetn = 1'b1;
        run_access(4'b0000, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_access(legal_wen[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                quiet_inputs();
                #1 check_eq("gap_stall", 64'(cpu_stall), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
